// File: rtl/imu_sample_feeder.sv
// Queues raw IMU samples and feeds the attitude filter one at a time, holding each result for the host.
// Latency: a sample written into an empty FIFO drives valid_in two edges later; s_ready drops only when the FIFO is full.
module imu_sample_feeder #(
   parameter int ACC_W   = 11,
   parameter int GYRO_W  = 14,
   parameter int Q_W     = 16,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic signed [ACC_W-1:0]   s_a_x,
   input  logic signed [ACC_W-1:0]   s_a_y,
   input  logic signed [ACC_W-1:0]   s_a_z,
   input  logic signed [GYRO_W-1:0]  s_w_x,
   input  logic signed [GYRO_W-1:0]  s_w_y,
   input  logic signed [GYRO_W-1:0]  s_w_z,
   output logic                      valid_in,
   input  logic                      ready_in,
   output logic signed [ACC_W-1:0]   a_x,
   output logic signed [ACC_W-1:0]   a_y,
   output logic signed [ACC_W-1:0]   a_z,
   output logic signed [GYRO_W-1:0]  w_x,
   output logic signed [GYRO_W-1:0]  w_y,
   output logic signed [GYRO_W-1:0]  w_z,
   input  logic                      valid_out,
   output logic                      ready_out,
   input  logic signed [Q_W-1:0]     q_w_norm_output,
   input  logic signed [Q_W-1:0]     q_x_norm_output,
   input  logic signed [Q_W-1:0]     q_y_norm_output,
   input  logic signed [Q_W-1:0]     q_z_norm_output,
   output logic                      res_valid,
   output logic signed [Q_W-1:0]     res_q_w,
   output logic signed [Q_W-1:0]     res_q_x,
   output logic signed [Q_W-1:0]     res_q_y,
   output logic signed [Q_W-1:0]     res_q_z,
   output logic [7:0]                res_seq,
   input  logic                      rd_ack,
   input  logic                      err_clr,
   output logic [$clog2(DEPTH):0]    fifo_level,
   output logic                      err_timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef struct packed {
      logic signed [ACC_W-1:0]  ax;
      logic signed [ACC_W-1:0]  ay;
      logic signed [ACC_W-1:0]  az;
      logic signed [GYRO_W-1:0] wx;
      logic signed [GYRO_W-1:0] wy;
      logic signed [GYRO_W-1:0] wz;
   } sample_t;

   typedef struct packed {
      logic signed [Q_W-1:0] qw;
      logic signed [Q_W-1:0] qx;
      logic signed [Q_W-1:0] qy;
      logic signed [Q_W-1:0] qz;
   } quat_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES} state_t;

   sample_t       r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   sample_t       r_issue;
   logic          r_valid_in;
   quat_t         r_res;
   logic          r_res_valid;
   logic [7:0]    r_res_seq;
   logic          r_err;
   logic [TW-1:0] r_tcnt;
   state_t        r_state;

   state_t        w_state_nxt;
   sample_t       w_wr_dat;
   quat_t         w_q_in;
   logic          w_push;
   logic          w_pop;
   logic          w_load;
   logic          w_capture;
   logic          w_timeout;
   logic          w_ready_out;
   logic          w_full;

   assign w_wr_dat = '{ax: s_a_x, ay: s_a_y, az: s_a_z, wx: s_w_x, wy: s_w_y, wz: s_w_z};
   assign w_q_in   = '{qw: q_w_norm_output, qx: q_x_norm_output,
                       qy: q_y_norm_output, qz: q_z_norm_output};

   assign w_full  = (r_level == (AW+1)'(DEPTH));
   assign w_push  = s_valid && !w_full;
   assign s_ready = !w_full;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_wr_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_pop       = 1'b0;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      w_ready_out = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_level != '0) begin
               w_load      = 1'b1;
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (r_valid_in && ready_in) begin
               w_pop       = 1'b1;
               w_state_nxt = WAIT_RES;
            end
         end
         WAIT_RES: begin
            // A held, unread result blocks the filter unless the host frees it this same edge.
            w_ready_out = !r_res_valid || rd_ack;
            w_capture   = valid_out && w_ready_out;
            if (w_capture) begin
               w_state_nxt = IDLE;
            end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
               w_timeout   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign ready_out = w_ready_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_issue    <= '0;
         r_valid_in <= 1'b0;
      end else if (w_load) begin
         r_issue    <= r_mem[r_rd_ptr];
         r_valid_in <= 1'b1;
      end else if (w_pop) begin
         r_valid_in <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                      r_tcnt <= '0;
      else if (r_state != WAIT_RES) r_tcnt <= '0;
      else if (!w_capture)          r_tcnt <= r_tcnt + TW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_res       <= '0;
         r_res_valid <= 1'b0;
         r_res_seq   <= '0;
      end else if (w_capture) begin
         r_res       <= w_q_in;
         r_res_valid <= 1'b1;
         r_res_seq   <= r_res_seq + 8'd1;
      end else if (rd_ack && r_res_valid) begin
         r_res_valid <= 1'b0;
      end
   end

   // A timeout on the same edge as err_clr keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst)            r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;
      else if (err_clr)   r_err <= 1'b0;
   end

   assign valid_in    = r_valid_in;
   assign a_x         = r_issue.ax;
   assign a_y         = r_issue.ay;
   assign a_z         = r_issue.az;
   assign w_x         = r_issue.wx;
   assign w_y         = r_issue.wy;
   assign w_z         = r_issue.wz;
   assign res_valid   = r_res_valid;
   assign res_q_w     = r_res.qw;
   assign res_q_x     = r_res.qx;
   assign res_q_y     = r_res.qy;
   assign res_q_z     = r_res.qz;
   assign res_seq     = r_res_seq;
   assign fifo_level  = r_level;
   assign err_timeout = r_err;

endmodule

// File: doc/imu_sample_feeder.md
IMU_SAMPLE_FEEDER -- requirements
Module: imu_sample_feeder

Interface
REQ-001 Parameter ACC_W, default 11, accelerometer axis width (signed).
REQ-002 Parameter GYRO_W, default 14, gyroscope axis width (signed).
REQ-003 Parameter Q_W, default 16, quaternion component width (signed).
REQ-004 Parameter DEPTH, default 4, sample FIFO entries, power of two, >=2.
REQ-005 Parameter TIMEOUT, default 1000, max cycles in WAIT_RES before abort.
REQ-006 The block SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 s_valid / s_ready  in / out  1 / 1  sensor-side sample handshake.
REQ-010 s_a_x, s_a_y, s_a_z  in  ACC_W each  raw accel sample; s_w_x, s_w_y, s_w_z  in  GYRO_W each  raw gyro sample.
REQ-011 valid_in  out  1, ready_in  in  1  filter input handshake.
REQ-012 a_x, a_y, a_z  out  ACC_W; w_x, w_y, w_z  out  GYRO_W  filter input sample.
REQ-013 valid_out  in  1, ready_out  out  1  filter output handshake.
REQ-014 q_w_norm_output, q_x_norm_output, q_y_norm_output, q_z_norm_output  in  Q_W each  filter result.
REQ-015 res_valid  out  1; res_q_w, res_q_x, res_q_y, res_q_z  out  Q_W; res_seq  out  8  held result for host.
REQ-016 rd_ack  in  1  host consumed result; err_clr  in  1  clears error.
REQ-017 fifo_level  out  clog2(DEPTH)+1  occupancy; err_timeout  out  1  sticky timeout flag.

Function
REQ-018 FIFO push on s_valid && s_ready; s_ready SHALL equal !full (combinational from level only).
REQ-019 Push and pop in the same cycle SHALL leave fifo_level unchanged; pointers wrap modulo DEPTH.
REQ-020 FSM states IDLE, ISSUE, WAIT_RES; one sample in flight at most.
REQ-021 IDLE -> ISSUE on an edge where fifo_level != 0; at that edge valid_in <= 1 and a_*/w_* <= FIFO head.
REQ-022 In ISSUE, valid_in and a_*/w_* SHALL hold stable until valid_in && ready_in; at that edge pop FIFO, valid_in <= 0, enter WAIT_RES, clear timeout counter.
REQ-023 ISSUE SHALL wait on ready_in indefinitely (no timeout).
REQ-024 In WAIT_RES, ready_out SHALL be (!res_valid || rd_ack); ready_out SHALL be 0 in IDLE and ISSUE.
REQ-025 On valid_out && ready_out: res_q_* <= q_*_norm_output, res_valid <= 1, res_seq <= res_seq+1 (wraps 255->0), state -> IDLE.
REQ-026 rd_ack with res_valid clears res_valid next edge unless a capture occurs the same edge (capture wins, res_valid stays 1); rd_ack with !res_valid is ignored.
REQ-027 Timeout counter increments each WAIT_RES cycle with no capture; on reaching TIMEOUT: err_timeout <= 1, state -> IDLE, sample discarded, res_seq unchanged.
REQ-028 A valid_out arriving outside WAIT_RES SHALL be ignored (ready_out 0).
REQ-029 err_clr clears err_timeout; a same-edge timeout event SHALL win (flag stays 1).
REQ-030 Minimum cycle: write edge N into empty FIFO in IDLE -> valid_in high after edge N+1.

Reset
REQ-031 On rst high at any edge, including mid-transaction: FIFO empty, fifo_level 0, s_ready 1, state IDLE, valid_in 0, ready_out 0, a_*/w_* 0, res_valid 0, res_q_* 0, res_seq 0, err_timeout 0, timeout counter 0.

Verification
REQ-032 Push a_x=0x7B8, a_y=0x14A, a_z=0x0C4, w_x=0x3F1F, w_y=0x005C, w_z=0x3F54; ready_in=1 -> valid_in high after 2 edges with those values, one-cycle handshake, then WAIT_RES with ready_out=1.
REQ-033 Filter returns q_w=0x4000 with valid_out one cycle -> res_valid=1, res_q_w=0x4000, res_seq=1; rd_ack -> res_valid=0 next edge.
REQ-034 Push 5 samples with DEPTH=4, ready_in=0 -> after 4 pushes s_ready=0, fifo_level=4; fifo_level drops to 3 one edge after ready_in rises, and the 5th sample is accepted.
REQ-035 Hold res_valid=1 without rd_ack while in WAIT_RES -> ready_out=0; assert rd_ack and valid_out together -> new result captured, res_valid remains 1, res_seq increments.
REQ-036 No valid_out for TIMEOUT cycles in WAIT_RES -> err_timeout=1, state IDLE, next FIFO sample issued; err_clr -> err_timeout=0.
REQ-037 Assert rst while valid_in=1 in ISSUE with fifo_level=2 -> next edge all outputs at REQ-031 values.
